// File: rtl/icache_param.sv
// Parametrised direct-mapped instruction cache with multi-word blocks, sequential fill with abort, and flush.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_param #(
   parameter int SETS  = 16,
   parameter int WORDS = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   input  logic        iflush,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int BOFF_W = $clog2(WORDS);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = 30 - IDX_W - BOFF_W;
   localparam int CNT_W  = (BOFF_W == 0) ? 1 : BOFF_W;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t             state, state_n;
   logic [29:0]        waddr;
   logic [TAG_W-1:0]   tag;
   logic [IDX_W-1:0]   idx;
   logic [CNT_W-1:0]   boff;
   logic [29:0]        fill_waddr;

   logic [31:0]        data_arr [SETS][WORDS];
   logic [TAG_W-1:0]   tag_arr  [SETS];
   logic [SETS-1:0]    valid;

   logic [TAG_W-1:0]   miss_tag;
   logic [IDX_W-1:0]   miss_idx;
   logic [CNT_W-1:0]   fill_cnt;

   logic               start_miss, fill_wr, fill_last, abort;
   logic               unused_addr_lsb;

   assign unused_addr_lsb = ^imemaddr[1:0];
   assign waddr = imemaddr[31:2];
   assign tag   = waddr[29:IDX_W+BOFF_W];
   assign idx   = waddr[IDX_W+BOFF_W-1:BOFF_W];

   // Single-word blocks have no block-offset field at all.
   generate
      if (BOFF_W == 0) begin : g_no_boff
         assign boff       = '0;
         assign fill_waddr = {miss_tag, miss_idx};
      end else begin : g_boff
         assign boff       = waddr[BOFF_W-1:0];
         assign fill_waddr = {miss_tag, miss_idx, fill_cnt};
      end
   endgenerate

   assign ihit     = imemREN & valid[idx] & (tag_arr[idx] == tag) & ~iflush;
   assign imemload = ihit ? data_arr[idx][boff] : 32'h0;

   always_ff @(posedge CLK) begin
      if (!nRST) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n    = state;
      start_miss = 1'b0;
      fill_wr    = 1'b0;
      fill_last  = 1'b0;
      abort      = 1'b0;
      iREN       = 1'b0;
      iaddr      = 32'h0;
      case (state)
         IDLE: begin
            if (imemREN & ~ihit & ~iflush) begin
               start_miss = 1'b1;
               state_n    = FILL;
            end
         end
         FILL: begin
            iREN  = 1'b1;
            iaddr = {fill_waddr, 2'b00};
            // Any redirect or dropped request abandons the fill before data is written.
            abort = ~imemREN | ({tag, idx} != {miss_tag, miss_idx});
            if (iflush | abort) begin
               state_n = IDLE;
            end else if (~iwait) begin
               fill_wr = 1'b1;
               if (fill_cnt == LAST_CNT) begin
                  fill_last = 1'b1;
                  state_n   = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         valid    <= '0;
         miss_tag <= '0;
         miss_idx <= '0;
         fill_cnt <= '0;
      end else begin
         if (iflush)          valid           <= '0;
         else if (start_miss) valid[idx]      <= 1'b0;
         else if (fill_last)  valid[miss_idx] <= 1'b1;

         if (start_miss) begin
            miss_tag <= tag;
            miss_idx <= idx;
            fill_cnt <= '0;
         end else if (fill_wr && !fill_last) begin
            fill_cnt <= fill_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (nRST && fill_wr)   data_arr[miss_idx][fill_cnt] <= iload;
      if (nRST && fill_last) tag_arr[miss_idx]            <= miss_tag;
   end

`ifdef ICACHE_PERF_CNT_EN
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (state == IDLE && ihit && hit_count != 32'hFFFF_FFFF)
            hit_count <= hit_count + 32'd1;
         if (start_miss && miss_count != 32'hFFFF_FFFF)
            miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_param.sv
// Directed bench for icache_param: vector table on a 16x2 cache, plus a 4x1 instance
// and (when ICACHE_PERF_CNT_EN is defined) a counter sequence.
module tb_icache_param;

   logic        CLK = 1'b0;
   logic        nRST, imemREN, iflush, iwait;
   logic [31:0] imemaddr, iload;
   logic        ihit, iREN;
   logic [31:0] imemload, iaddr;

   logic        nRST1, imemREN1, iwait1;
   logic [31:0] imemaddr1, iload1;
   logic        ihit1, iREN1;
   logic [31:0] imemload1, iaddr1;

`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_count, miss_count, hit_count1, miss_count1;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   icache_param #(.SETS(16), .WORDS(2)) dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload)
`ifdef ICACHE_PERF_CNT_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   icache_param #(.SETS(4), .WORDS(1)) dut1 (
      .CLK(CLK), .nRST(nRST1), .imemREN(imemREN1), .imemaddr(imemaddr1), .iflush(1'b0),
      .ihit(ihit1), .imemload(imemload1), .iREN(iREN1), .iaddr(iaddr1),
      .iwait(iwait1), .iload(iload1)
`ifdef ICACHE_PERF_CNT_EN
      , .hit_count(hit_count1), .miss_count(miss_count1)
`endif
   );

   typedef struct packed {
      logic        nrst, ren, flush, iw;
      logic [31:0] addr, ild;
      logic        ehit;
      logic [31:0] eload;
      logic        eiren;
      logic [31:0] eiaddr;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(logic nrst, logic ren, logic flush, logic iw,
                               logic [31:0] addr, logic [31:0] ild, logic ehit,
                               logic [31:0] eload, logic eiren, logic [31:0] eiaddr);
      vec_t v;
      v.nrst = nrst; v.ren = ren; v.flush = flush; v.iw = iw;
      v.addr = addr; v.ild = ild; v.ehit = ehit; v.eload = eload;
      v.eiren = eiren; v.eiaddr = eiaddr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic ren, input logic fl, input logic iw,
                       input logic [31:0] addr, input logic [31:0] ild);
      imemREN = ren; iflush = fl; iwait = iw; imemaddr = addr; iload = ild;
      @(posedge CLK); #1;
   endtask

   initial begin
      nRST = 0; imemREN = 0; iflush = 0; iwait = 1; imemaddr = 0; iload = 0;
      nRST1 = 0; imemREN1 = 0; iwait1 = 1; imemaddr1 = 0; iload1 = 0;

      //      nrst ren fl iw addr        iload         hit  load          iREN iaddr
      tv.push_back(mk(1,0,0,1, 32'h000, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,1,0,1, 32'h040, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,1,0,1, 32'h040, 32'h0,        0, 32'h0,        1, 32'h040));
      tv.push_back(mk(1,1,0,1, 32'h040, 32'h0,        0, 32'h0,        1, 32'h040));
      tv.push_back(mk(1,1,0,0, 32'h040, 32'hAAAA0000, 0, 32'h0,        1, 32'h040));
      tv.push_back(mk(1,1,0,0, 32'h040, 32'hAAAA0001, 0, 32'h0,        1, 32'h044));
      tv.push_back(mk(1,1,0,1, 32'h040, 32'h0,        1, 32'hAAAA0000, 0, 32'h000));
      tv.push_back(mk(1,1,0,1, 32'h044, 32'h0,        1, 32'hAAAA0001, 0, 32'h000));
      // conflict eviction in set 8
      tv.push_back(mk(1,1,0,1, 32'h0C0, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,1,0,0, 32'h0C0, 32'hBBBB0000, 0, 32'h0,        1, 32'h0C0));
      tv.push_back(mk(1,1,0,0, 32'h0C0, 32'hBBBB0001, 0, 32'h0,        1, 32'h0C4));
      tv.push_back(mk(1,1,0,1, 32'h0C4, 32'h0,        1, 32'hBBBB0001, 0, 32'h000));
      tv.push_back(mk(1,1,0,1, 32'h040, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,1,0,1, 32'h040, 32'h0,        0, 32'h0,        1, 32'h040));
      tv.push_back(mk(1,0,0,1, 32'h040, 32'h0,        0, 32'h0,        1, 32'h040));
      tv.push_back(mk(1,0,0,1, 32'h040, 32'h0,        0, 32'h0,        0, 32'h000));
      // fill abort by redirect 0x80 -> 0x200
      tv.push_back(mk(1,1,0,1, 32'h080, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,1,0,0, 32'h080, 32'hCCCC0000, 0, 32'h0,        1, 32'h080));
      tv.push_back(mk(1,1,0,0, 32'h200, 32'hDEAD0000, 0, 32'h0,        1, 32'h084));
      tv.push_back(mk(1,1,0,1, 32'h200, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,1,0,1, 32'h200, 32'h0,        0, 32'h0,        1, 32'h200));
      tv.push_back(mk(1,1,0,0, 32'h200, 32'h11110000, 0, 32'h0,        1, 32'h200));
      tv.push_back(mk(1,1,0,0, 32'h200, 32'h11110001, 0, 32'h0,        1, 32'h204));
      tv.push_back(mk(1,1,0,1, 32'h204, 32'h0,        1, 32'h11110001, 0, 32'h000));
      tv.push_back(mk(1,1,0,1, 32'h080, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,0,0,1, 32'h080, 32'h0,        0, 32'h0,        1, 32'h080));
      tv.push_back(mk(1,0,0,1, 32'h000, 32'h0,        0, 32'h0,        0, 32'h000));
      // warm sets 1 and 2, then flush during a fill of 0x100
      tv.push_back(mk(1,1,0,1, 32'h008, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,1,0,0, 32'h008, 32'h08080000, 0, 32'h0,        1, 32'h008));
      tv.push_back(mk(1,1,0,0, 32'h008, 32'h08080001, 0, 32'h0,        1, 32'h00C));
      tv.push_back(mk(1,1,0,1, 32'h00C, 32'h0,        1, 32'h08080001, 0, 32'h000));
      tv.push_back(mk(1,1,0,1, 32'h010, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,1,0,0, 32'h010, 32'h10100000, 0, 32'h0,        1, 32'h010));
      tv.push_back(mk(1,1,0,0, 32'h010, 32'h10100001, 0, 32'h0,        1, 32'h014));
      tv.push_back(mk(1,1,0,1, 32'h010, 32'h0,        1, 32'h10100000, 0, 32'h000));
      tv.push_back(mk(1,1,0,1, 32'h100, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,1,0,0, 32'h100, 32'h00000005, 0, 32'h0,        1, 32'h100));
      tv.push_back(mk(1,1,1,0, 32'h100, 32'h00000006, 0, 32'h0,        1, 32'h104));
      tv.push_back(mk(1,1,0,1, 32'h100, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,0,0,1, 32'h100, 32'h0,        0, 32'h0,        1, 32'h100));
      tv.push_back(mk(1,1,0,1, 32'h008, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,0,0,1, 32'h008, 32'h0,        0, 32'h0,        1, 32'h008));
      tv.push_back(mk(1,1,0,1, 32'h010, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,0,0,1, 32'h010, 32'h0,        0, 32'h0,        1, 32'h010));
      tv.push_back(mk(1,0,0,1, 32'h000, 32'h0,        0, 32'h0,        0, 32'h000));
      // flush in IDLE masks a valid hit
      tv.push_back(mk(1,1,0,1, 32'h008, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,1,0,0, 32'h008, 32'h00000007, 0, 32'h0,        1, 32'h008));
      tv.push_back(mk(1,1,0,0, 32'h008, 32'h00000008, 0, 32'h0,        1, 32'h00C));
      tv.push_back(mk(1,1,1,1, 32'h00C, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,1,0,1, 32'h00C, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,0,0,1, 32'h00C, 32'h0,        0, 32'h0,        1, 32'h008));
      tv.push_back(mk(1,0,0,1, 32'h000, 32'h0,        0, 32'h0,        0, 32'h000));
      // reset mid-fill while iaddr = 0x44
      tv.push_back(mk(1,1,0,1, 32'h040, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,1,0,0, 32'h040, 32'h00000001, 0, 32'h0,        1, 32'h040));
      tv.push_back(mk(0,1,0,1, 32'h040, 32'h0,        0, 32'h0,        1, 32'h044));
      tv.push_back(mk(1,1,0,1, 32'h040, 32'h0,        0, 32'h0,        0, 32'h000));
      tv.push_back(mk(1,0,0,1, 32'h040, 32'h0,        0, 32'h0,        1, 32'h040));
      tv.push_back(mk(1,0,0,1, 32'h000, 32'h0,        0, 32'h0,        0, 32'h000));

      repeat (2) @(posedge CLK);
      #1;
      nRST1 = 1;

      foreach (tv[i]) begin
         nRST = tv[i].nrst; imemREN = tv[i].ren; iflush = tv[i].flush;
         iwait = tv[i].iw; imemaddr = tv[i].addr; iload = tv[i].ild;
         @(negedge CLK);
         chk($sformatf("v%0d ihit", i),     {31'b0, ihit}, {31'b0, tv[i].ehit});
         chk($sformatf("v%0d imemload", i), imemload,      tv[i].eload);
         chk($sformatf("v%0d iREN", i),     {31'b0, iREN}, {31'b0, tv[i].eiren});
         chk($sformatf("v%0d iaddr", i),    iaddr,         tv[i].eiaddr);
         @(posedge CLK); #1;
      end
      nRST = 1; imemREN = 0; iflush = 0; iwait = 1;

      // SETS=4, WORDS=1: single transfer fill, then reset mid-fill
      imemREN1 = 1; imemaddr1 = 32'h10; iwait1 = 1;
      @(negedge CLK);
      chk("w1 miss ihit", {31'b0, ihit1}, 32'h0);
      chk("w1 miss iREN", {31'b0, iREN1}, 32'h0);
      @(posedge CLK); #1;
      iwait1 = 0; iload1 = 32'h12345678;
      @(negedge CLK);
      chk("w1 fill iREN",  {31'b0, iREN1}, 32'h1);
      chk("w1 fill iaddr", iaddr1, 32'h10);
      @(posedge CLK); #1;
      iwait1 = 1; iload1 = 0;
      @(negedge CLK);
      chk("w1 hit ihit",     {31'b0, ihit1}, 32'h1);
      chk("w1 hit imemload", imemload1, 32'h12345678);
      chk("w1 hit iREN",     {31'b0, iREN1}, 32'h0);
      @(posedge CLK); #1;
      imemaddr1 = 32'h20;
      @(negedge CLK);
      chk("w1 miss2 ihit", {31'b0, ihit1}, 32'h0);
      @(posedge CLK); #1;
      nRST1 = 0;
      @(negedge CLK);
      chk("w1 rst iREN",  {31'b0, iREN1}, 32'h1);
      chk("w1 rst iaddr", iaddr1, 32'h20);
      @(posedge CLK); #1;
      nRST1 = 1; imemaddr1 = 32'h10;
      @(negedge CLK);
      chk("w1 post-rst ihit",  {31'b0, ihit1}, 32'h0);
      chk("w1 post-rst iREN",  {31'b0, iREN1}, 32'h0);
      chk("w1 post-rst iaddr", iaddr1, 32'h0);
      @(posedge CLK); #1;
      imemREN1 = 0;
      @(negedge CLK);
      chk("w1 refill iaddr", iaddr1, 32'h10);
      @(posedge CLK); #1;

`ifdef ICACHE_PERF_CNT_EN
      nRST = 0; step(0, 0, 1, 32'h0, 32'h0); nRST = 1;
      step(1, 0, 1, 32'h040, 32'h0);
      step(1, 0, 0, 32'h040, 32'h1);
      step(1, 0, 0, 32'h040, 32'h2);
      step(1, 0, 1, 32'h040, 32'h0);
      step(1, 0, 1, 32'h044, 32'h0);
      step(1, 0, 1, 32'h008, 32'h0);
      step(1, 0, 0, 32'h008, 32'h3);
      step(1, 0, 0, 32'h008, 32'h4);
      step(1, 0, 1, 32'h008, 32'h0);
      step(1, 0, 1, 32'h00C, 32'h0);
      step(1, 0, 1, 32'h008, 32'h0);
      step(1, 0, 1, 32'h200, 32'h0);
      step(0, 0, 1, 32'h200, 32'h0);
      step(0, 0, 1, 32'h000, 32'h0);
      @(negedge CLK);
      chk("perf miss_count", miss_count, 32'd3);
      chk("perf hit_count",  hit_count,  32'd5);
      @(posedge CLK); #1;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
